// File: rtl/mac_pkg.sv
// Shared MAC sequencer types: FSM state encoding and default datapath parameters.
package mac_pkg;

    localparam int unsigned MAC_ACC_W = 16;
    localparam int unsigned MAC_LAT   = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ACC   = 3'd1,
        ST_BIAS  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_OUT   = 3'd4,
        ST_DONE  = 3'd5
    } mac_ctl_state_e;

endpackage

// File: rtl/tx_pkg.sv
// Instruction payload carried from tx_top to the MAC sequencer.
package tx_pkg;

    typedef struct packed {
        logic [mac_pkg::MAC_ACC_W-1:0] acc_len;
        logic                          bias_en;
    } tx_mac_instruction_port;

endpackage

// File: rtl/mac_ctl_if.sv
// Handshake bundle between tx_top/mac_lane and the MAC sequencer; slave is the sequencer side.
interface mac_ctl_if #(
    parameter int unsigned ACC_W = mac_pkg::MAC_ACC_W
) ();
    import tx_pkg::*;

    logic                   ctl_o_instruction_ready;
    logic                   ctl_i_instruction_valid;
    tx_mac_instruction_port ctl_i_instruction;
    logic                   ctl_i_ifm_valid;
    logic                   ctl_o_ifm_ready;
    logic                   ctl_i_wfm_valid;
    logic                   ctl_o_wfm_ready;
    logic                   ctl_i_bias_valid;
    logic                   ctl_o_bias_ready;
    logic                   ctl_i_ofm_ready;
    logic                   ctl_o_ofm_valid;
    logic                   ctl_i_done_ready;
    logic                   ctl_o_done;
    logic                   ctl_o_acc_clr;
    logic                   ctl_o_acc_en;
    logic                   ctl_o_bias_add;
    logic                   ctl_o_ofm_hold;
    logic                   ctl_o_busy;
    logic [ACC_W-1:0]       ctl_o_beat_cnt;

    modport master (
        input  ctl_o_instruction_ready, ctl_o_ifm_ready, ctl_o_wfm_ready, ctl_o_bias_ready,
               ctl_o_ofm_valid, ctl_o_done, ctl_o_acc_clr, ctl_o_acc_en, ctl_o_bias_add,
               ctl_o_ofm_hold, ctl_o_busy, ctl_o_beat_cnt,
        output ctl_i_instruction_valid, ctl_i_instruction, ctl_i_ifm_valid, ctl_i_wfm_valid,
               ctl_i_bias_valid, ctl_i_ofm_ready, ctl_i_done_ready
    );

    modport slave (
        output ctl_o_instruction_ready, ctl_o_ifm_ready, ctl_o_wfm_ready, ctl_o_bias_ready,
               ctl_o_ofm_valid, ctl_o_done, ctl_o_acc_clr, ctl_o_acc_en, ctl_o_bias_add,
               ctl_o_ofm_hold, ctl_o_busy, ctl_o_beat_cnt,
        input  ctl_i_instruction_valid, ctl_i_instruction, ctl_i_ifm_valid, ctl_i_wfm_valid,
               ctl_i_bias_valid, ctl_i_ofm_ready, ctl_i_done_ready
    );

endinterface

// File: rtl/mac_ctl.sv
// MAC sequencer: one instruction at a time, joins ifm/wfm into accumulate beats,
// optional bias beat, pipeline drain, then ofm and done handshakes.
module mac_ctl
    import mac_pkg::*;
#(
    parameter int unsigned ACC_W = MAC_ACC_W,
    parameter int unsigned LAT   = MAC_LAT
) (
    input  logic     clk,
    input  logic     rst,
    mac_ctl_if.slave bus
);

    localparam int unsigned LAT_W = (LAT < 2) ? 1 : $clog2(LAT);

    mac_ctl_state_e   state_q, state_d;
    logic [ACC_W-1:0] acc_len_q, acc_len_d;
    logic [ACC_W-1:0] beat_cnt_q, beat_cnt_d;
    logic             bias_en_q, bias_en_d;
    logic [LAT_W-1:0] lat_cnt_q, lat_cnt_d;
    logic             acc_clr_q, acc_clr_d;

    logic instr_hs;
    logic fire;
    logic last_beat;
    logic lat_done;

    // Stream handshakes are suppressed while reset is held so in-flight beats are not acknowledged.
    assign instr_hs  = (state_q == ST_IDLE) && bus.ctl_i_instruction_valid;
    assign fire      = !rst && (state_q == ST_ACC) && bus.ctl_i_ifm_valid && bus.ctl_i_wfm_valid;
    assign last_beat = (beat_cnt_q == (acc_len_q - ACC_W'(1)));
    assign lat_done  = (LAT == 0) || (lat_cnt_q == LAT_W'(LAT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            acc_len_q  <= '0;
            beat_cnt_q <= '0;
            bias_en_q  <= 1'b0;
            lat_cnt_q  <= '0;
            acc_clr_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_len_q  <= acc_len_d;
            beat_cnt_q <= beat_cnt_d;
            bias_en_q  <= bias_en_d;
            lat_cnt_q  <= lat_cnt_d;
            acc_clr_q  <= acc_clr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        acc_len_d  = acc_len_q;
        beat_cnt_d = beat_cnt_q;
        bias_en_d  = bias_en_q;
        lat_cnt_d  = '0;
        acc_clr_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (instr_hs) begin
                    acc_len_d  = ACC_W'(bus.ctl_i_instruction.acc_len);
                    bias_en_d  = bus.ctl_i_instruction.bias_en;
                    beat_cnt_d = '0;
                    acc_clr_d  = 1'b1;
                    if (bus.ctl_i_instruction.acc_len != '0)
                        state_d = ST_ACC;
                    else if (bus.ctl_i_instruction.bias_en)
                        state_d = ST_BIAS;
                    else
                        state_d = ST_DRAIN;
                end
            end
            ST_ACC: begin
                if (fire) begin
                    beat_cnt_d = beat_cnt_q + ACC_W'(1);
                    if (last_beat)
                        state_d = bias_en_q ? ST_BIAS : ST_DRAIN;
                end
            end
            ST_BIAS: begin
                if (bus.ctl_i_bias_valid)
                    state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (lat_done)
                    state_d = ST_OUT;
                else
                    lat_cnt_d = lat_cnt_q + LAT_W'(1);
            end
            ST_OUT: begin
                if (bus.ctl_i_ofm_ready)
                    state_d = ST_DONE;
            end
            ST_DONE: begin
                if (bus.ctl_i_done_ready)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Valid/hold outputs decode state only; readies and strobes may follow the valid inputs.
    always_comb begin
        bus.ctl_o_instruction_ready = (state_q == ST_IDLE);
        bus.ctl_o_ifm_ready         = fire;
        bus.ctl_o_wfm_ready         = fire;
        bus.ctl_o_acc_en            = fire;
        bus.ctl_o_bias_ready        = !rst && (state_q == ST_BIAS);
        bus.ctl_o_bias_add          = !rst && (state_q == ST_BIAS) && bus.ctl_i_bias_valid;
        bus.ctl_o_ofm_valid         = (state_q == ST_OUT);
        bus.ctl_o_ofm_hold          = (state_q == ST_OUT);
        bus.ctl_o_done              = (state_q == ST_DONE);
        bus.ctl_o_busy              = (state_q != ST_IDLE);
        bus.ctl_o_acc_clr           = acc_clr_q;
        bus.ctl_o_beat_cnt          = beat_cnt_q;
    end

endmodule

// File: tb/tb_mac_ctl.sv
// Directed bench for mac_ctl: vector table for the main flows plus hand sequences for stalls, reset and max length.
module tb_mac_ctl;
    import tx_pkg::*;

    logic clk;
    logic rst;

    mac_ctl_if #(.ACC_W(16)) m ();
    mac_ctl_if #(.ACC_W(16)) s ();

    mac_ctl #(.ACC_W(16), .LAT(2)) u_dut   (.clk(clk), .rst(rst), .bus(m));
    mac_ctl #(.ACC_W(16), .LAT(1)) u_dut_l1 (.clk(clk), .rst(rst), .bus(s));

    assign s.ctl_i_instruction_valid = m.ctl_i_instruction_valid;
    assign s.ctl_i_instruction       = m.ctl_i_instruction;
    assign s.ctl_i_ifm_valid         = m.ctl_i_ifm_valid;
    assign s.ctl_i_wfm_valid         = m.ctl_i_wfm_valid;
    assign s.ctl_i_bias_valid        = m.ctl_i_bias_valid;
    assign s.ctl_i_ofm_ready         = m.ctl_i_ofm_ready;
    assign s.ctl_i_done_ready        = m.ctl_i_done_ready;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {ir, ifm_r, wfm_r, acc_en, acc_clr, bias_r, bias_add, ofm_v, ofm_hold, done, busy, beat_cnt}
    logic [26:0] m_out, s_out;
    assign m_out = {m.ctl_o_instruction_ready, m.ctl_o_ifm_ready, m.ctl_o_wfm_ready, m.ctl_o_acc_en,
                    m.ctl_o_acc_clr, m.ctl_o_bias_ready, m.ctl_o_bias_add, m.ctl_o_ofm_valid,
                    m.ctl_o_ofm_hold, m.ctl_o_done, m.ctl_o_busy, m.ctl_o_beat_cnt};
    assign s_out = {s.ctl_o_instruction_ready, s.ctl_o_ifm_ready, s.ctl_o_wfm_ready, s.ctl_o_acc_en,
                    s.ctl_o_acc_clr, s.ctl_o_bias_ready, s.ctl_o_bias_add, s.ctl_o_ofm_valid,
                    s.ctl_o_ofm_hold, s.ctl_o_done, s.ctl_o_busy, s.ctl_o_beat_cnt};

    localparam logic [10:0] O_IDLE  = 11'b10000000000;
    localparam logic [10:0] O_FCLR  = 11'b01111000001;
    localparam logic [10:0] O_FIRE  = 11'b01110000001;
    localparam logic [10:0] O_BIAS  = 11'b00000110001;
    localparam logic [10:0] O_BUSY  = 11'b00000000001;
    localparam logic [10:0] O_OUT   = 11'b00000001101;
    localparam logic [10:0] O_DONE  = 11'b00000000011;

    typedef struct {
        logic        rst;
        logic        iv;
        logic [15:0] len;
        logic        ben;
        logic        ifv;
        logic        wfv;
        logic        bv;
        logic        ofr;
        logic        dnr;
        logic [10:0] eo;
        logic [15:0] ebeat;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic [15:0] len, input logic ben,
                         input logic ifv, input logic wfv, input logic bv,
                         input logic ofr, input logic dnr);
        m.ctl_i_instruction_valid = iv;
        m.ctl_i_instruction       = '{acc_len: len, bias_en: ben};
        m.ctl_i_ifm_valid         = ifv;
        m.ctl_i_wfm_valid         = wfv;
        m.ctl_i_bias_valid        = bv;
        m.ctl_i_ofm_ready         = ofr;
        m.ctl_i_done_ready        = dnr;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic finish_op();
        logic ok;
        ok = 1'b0;
        drive(1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        for (int k = 0; k < 20; k++) begin
            #1;
            if (m.ctl_o_instruction_ready && s.ctl_o_instruction_ready) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        chk("idle_return", 32'(ok), 32'd1);
        m.ctl_i_ofm_ready  = 1'b0;
        m.ctl_i_done_ready = 1'b0;
        step();
    endtask

    vec_t tbl[23];

    initial begin
        int first_s, first_m, n_en;
        logic [15:0] last_cnt;

        tbl[0]  = '{1, 0, 16'd4, 1, 1, 1, 1, 1, 1, O_IDLE, 16'd0};
        tbl[1]  = '{0, 1, 16'd4, 1, 1, 1, 1, 1, 1, O_IDLE, 16'd0};
        tbl[2]  = '{0, 0, 16'd4, 1, 1, 1, 1, 1, 1, O_FCLR, 16'd0};
        tbl[3]  = '{0, 0, 16'd4, 1, 1, 1, 1, 1, 1, O_FIRE, 16'd1};
        tbl[4]  = '{0, 0, 16'd4, 1, 1, 1, 1, 1, 1, O_FIRE, 16'd2};
        tbl[5]  = '{0, 0, 16'd4, 1, 1, 1, 1, 1, 1, O_FIRE, 16'd3};
        tbl[6]  = '{0, 0, 16'd4, 1, 1, 1, 1, 1, 1, O_BIAS, 16'd4};
        tbl[7]  = '{0, 0, 16'd4, 1, 1, 1, 1, 1, 1, O_BUSY, 16'd4};
        tbl[8]  = '{0, 0, 16'd4, 1, 1, 1, 1, 1, 1, O_BUSY, 16'd4};
        tbl[9]  = '{0, 0, 16'd4, 1, 1, 1, 1, 1, 1, O_OUT,  16'd4};
        tbl[10] = '{0, 0, 16'd4, 1, 1, 1, 1, 1, 1, O_DONE, 16'd4};
        tbl[11] = '{0, 0, 16'd4, 1, 1, 1, 1, 1, 1, O_IDLE, 16'd4};
        tbl[12] = '{0, 1, 16'd3, 0, 1, 0, 0, 1, 1, O_IDLE, 16'd4};
        tbl[13] = '{0, 0, 16'd3, 0, 1, 1, 0, 1, 1, O_FCLR, 16'd0};
        tbl[14] = '{0, 0, 16'd3, 0, 1, 0, 0, 1, 1, O_BUSY, 16'd1};
        tbl[15] = '{0, 0, 16'd3, 0, 1, 1, 0, 1, 1, O_FIRE, 16'd1};
        tbl[16] = '{0, 0, 16'd3, 0, 1, 0, 0, 1, 1, O_BUSY, 16'd2};
        tbl[17] = '{0, 0, 16'd3, 0, 1, 1, 0, 1, 1, O_FIRE, 16'd2};
        tbl[18] = '{0, 0, 16'd3, 0, 1, 0, 0, 1, 1, O_BUSY, 16'd3};
        tbl[19] = '{0, 0, 16'd3, 0, 1, 0, 0, 1, 1, O_BUSY, 16'd3};
        tbl[20] = '{0, 0, 16'd3, 0, 1, 0, 0, 1, 1, O_OUT,  16'd3};
        tbl[21] = '{0, 0, 16'd3, 0, 1, 0, 0, 1, 1, O_DONE, 16'd3};
        tbl[22] = '{0, 0, 16'd3, 0, 1, 0, 0, 1, 1, O_IDLE, 16'd3};

        rst = 1'b1;
        drive(1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 23; i++) begin
            rst = tbl[i].rst;
            drive(tbl[i].iv, tbl[i].len, tbl[i].ben, tbl[i].ifv, tbl[i].wfv,
                  tbl[i].bv, tbl[i].ofr, tbl[i].dnr);
            #1;
            chk($sformatf("vec%0d", i), 32'(m_out), 32'({tbl[i].eo, tbl[i].ebeat}));
            step();
        end

        // acc_len=0, bias_en=0: no stream beats, ofm at t+2 (LAT=1) and t+3 (LAT=2)
        drive(1'b1, 16'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        #1;
        chk("zero_accept", 32'(s.ctl_o_instruction_ready), 32'd1);
        step();
        m.ctl_i_instruction_valid = 1'b0;
        first_s = -1;
        first_m = -1;
        for (int k = 1; k <= 6; k++) begin
            #1;
            chk($sformatf("zero_rdy%0d", k), 32'({s_out[25:24], s_out[21]}), 32'd0);
            if (k == 2)
                chk("zero_out_l1", 32'(s_out), 32'({O_OUT, 16'd0}));
            if (s.ctl_o_ofm_valid && first_s < 0) first_s = k;
            if (m.ctl_o_ofm_valid && first_m < 0) first_m = k;
            step();
        end
        chk("zero_lat_l1", 32'(first_s), 32'd2);
        chk("zero_lat_l2", 32'(first_m), 32'd3);
        finish_op();

        // ofm and done back-pressure
        drive(1'b1, 16'd1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        m.ctl_i_instruction_valid = 1'b0;
        first_m = -1;
        for (int k = 0; k < 10; k++) begin
            #1;
            if (m.ctl_o_ofm_valid) begin
                first_m = k;
                break;
            end
            step();
        end
        chk("bp_ofm_seen", 32'(first_m >= 0), 32'd1);
        for (int j = 0; j < 5; j++) begin
            if (j > 0) begin
                @(posedge clk);
                #2;
            end
            chk($sformatf("bp_ofm%0d", j), 32'({m.ctl_o_ofm_valid, m.ctl_o_ofm_hold,
                m.ctl_o_instruction_ready, m.ctl_o_done}), 32'b1100);
        end
        step();
        m.ctl_i_ofm_ready = 1'b1;
        #1;
        chk("bp_ofm_hs", 32'({m.ctl_o_ofm_valid, m.ctl_o_done}), 32'b10);
        step();
        m.ctl_i_ofm_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
            #1;
            chk($sformatf("bp_done%0d", j), 32'({m.ctl_o_ofm_valid, m.ctl_o_done,
                m.ctl_o_instruction_ready}), 32'b010);
            step();
        end
        m.ctl_i_done_ready = 1'b1;
        #1;
        chk("bp_done_hs", 32'({m.ctl_o_done, m.ctl_o_instruction_ready}), 32'b10);
        step();
        m.ctl_i_done_ready = 1'b0;
        #1;
        chk("bp_idle", 32'({m.ctl_o_instruction_ready, m.ctl_o_busy}), 32'b10);
        step();
        finish_op();

        // reset in ACC after 2 of 8 beats
        drive(1'b1, 16'd8, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        m.ctl_i_instruction_valid = 1'b0;
        step();
        step();
        rst = 1'b1;
        #1;
        chk("rst_noack", 32'({m.ctl_o_ifm_ready, m.ctl_o_wfm_ready, m.ctl_o_acc_en}), 32'd0);
        step();
        rst = 1'b0;
        drive(1'b1, 16'd1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        chk("rst_idle", 32'(m_out), 32'({O_IDLE, 16'd0}));
        step();
        m.ctl_i_instruction_valid = 1'b0;
        #1;
        chk("rst_new_instr", 32'(m_out), 32'({O_FCLR, 16'd0}));
        step();
        finish_op();

        // maximum acc_len: counter reaches 2^16-2 on the final beat and exits without wrapping
        drive(1'b1, 16'hFFFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        m.ctl_i_instruction_valid = 1'b0;
        n_en = 0;
        last_cnt = '0;
        for (int k = 0; k < 70000; k++) begin
            #1;
            if (!m.ctl_o_acc_en) break;
            n_en++;
            last_cnt = m.ctl_o_beat_cnt;
            step();
        end
        chk("max_beats", 32'(n_en), 32'd65535);
        chk("max_last_cnt", 32'(last_cnt), 32'h0000FFFE);
        chk("max_exit", 32'(m_out), 32'({O_BUSY, 16'hFFFF}));
        step();
        finish_op();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mac_ctl.md
# mac_ctl

Sequencer for the MAC datapath. It accepts one MAC instruction at a time and joins the ifm/wfm streams into accumulate beats. It then optionally admits one bias beat, waits out the lane pipeline latency, and holds the ofm handshake. Finally it reports completion on the done handshake. It sits between the tx_top instruction/stream ports and the mac_lane array, and drives the lane control strobes.

## Interface
Parameters:
- ACC_W, 16, width of the accumulate-length field and of the beat counter
- LAT, 2, lane pipeline cycles from the last acc_en/bias_add until the ofm result is stable; 0 is legal

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- ctl_o_instruction_ready  out  1  instruction slot free
- ctl_i_instruction_valid  in  1  instruction offered
- ctl_i_instruction  in  tx_mac_instruction_port  fields: acc_len[ACC_W-1:0] (number of accumulate beats) and bias_en
- ctl_i_ifm_valid / ctl_o_ifm_ready  in/out  1  ifm stream handshake
- ctl_i_wfm_valid / ctl_o_wfm_ready  in/out  1  wfm stream handshake
- ctl_i_bias_valid / ctl_o_bias_ready  in/out  1  bias stream handshake
- ctl_i_ofm_ready / ctl_o_ofm_valid  in/out  1  ofm handshake; ofm data comes from the lanes
- ctl_i_done_ready / ctl_o_done  in/out  1  completion handshake
- ctl_o_acc_clr  out  1  single-cycle pulse that zeroes the lane accumulators
- ctl_o_acc_en  out  1  lanes accumulate ifm×wfm this cycle
- ctl_o_bias_add  out  1  lanes add bias this cycle
- ctl_o_ofm_hold  out  1  lanes freeze their result registers
- ctl_o_busy  out  1  state ≠ IDLE
- ctl_o_beat_cnt  out  ACC_W  accumulate beats consumed for the current instruction

## Operation
- The FSM has six states: IDLE, ACC, BIAS, DRAIN, OUT and DONE.
- IDLE:
  - instruction_ready=1.
  - On handshake, latch acc_len/bias_en, clear beat_cnt, register acc_clr=1 for the next cycle, and compute the next state:
    - acc_len≠0 → ACC
    - acc_len=0 and bias_en → BIAS
    - otherwise → DRAIN
- ACC:
  - fire = ifm_valid & wfm_valid.
  - ifm_ready = wfm_ready = fire; a lone valid is never accepted.
  - acc_en = fire, in the same cycle.
  - On fire, beat_cnt increments. If beat_cnt = acc_len−1, go to BIAS when bias_en is set, else to DRAIN.
- BIAS:
  - bias_ready=1.
  - On bias_valid, bias_add=1 in the same cycle, then go to DRAIN.
- DRAIN:
  - Wait LAT cycles using a latency counter, then go to OUT.
  - With LAT=0, DRAIN lasts one cycle.
- OUT:
  - ofm_valid=1 and ofm_hold=1.
  - On ofm_ready, go to DONE.
- DONE:
  - done=1.
  - On done_ready, go to IDLE.
- acc_len=0 with bias_en=0: no stream beats are consumed, and the ofm reads the cleared accumulator (zero).
- All ready/valid/strobe outputs are 0 outside the states named above.
- Once asserted, ofm_valid and done stay high, stable, until their handshake completes.
- beat_cnt arithmetic is unsigned and never wraps: the terminal compare exits ACC before overflow, and acc_len=2^ACC_W−1 is legal.
- Back-pressure:
  - ifm/wfm stalls hold the FSM in ACC.
  - A bias stall holds it in BIAS.
  - No counter advances without a handshake.

## Timing
- Reset: state=IDLE, instruction_ready=1, all other outputs 0, counters 0.
- Reset mid-operation abandons the instruction. The next cycle is IDLE, and in-flight stream beats are not acknowledged.
- Instruction accepted at cycle t:
  - acc_clr=1 at t+1.
  - The first acc_en can occur at t+1, coinciding with acc_clr. Lanes treat clr plus en as load.
- Minimum latency, with no stalls, from the instruction handshake to ofm_valid: 1 + acc_len + bias_en + max(LAT,1) cycles.
- done rises the cycle after the ofm handshake.
- instruction_ready rises the cycle after the done handshake. There is no overlap between instructions.
- Ready outputs may depend combinationally on valid inputs. Valid outputs never depend on ready inputs.

## Structure
- In mac_pkg:
  - mac_ctl_state_e, a 3-bit enum
  - the default localparams for ACC_W and LAT
- In tx_pkg: the acc_len and bias_en fields of tx_mac_instruction_port.
- No sub-module is needed: a single FSM plus two counters (beat, latency).
- mac instantiates mac_ctl alongside the mac_lane array.

## Test plan
- acc_len=4, bias_en=1, LAT=2, all streams always valid:
  - acc_clr at t+1
  - acc_en for 4 consecutive cycles
  - bias_add 1 cycle
  - ofm_valid 2 cycles later
  - done follows; total matches the latency formula.
- acc_len=3, ifm valid every cycle, wfm valid every other cycle:
  - exactly 3 acc_en pulses, each coinciding with both readies
  - ifm never accepted alone.
- acc_len=0, bias_en=0:
  - no stream readies ever assert
  - ofm_valid at t+2 with LAT=1.
- ofm_ready held low for 5 cycles, then done_ready held low for 3 cycles:
  - ofm_valid and done stay stable with ofm_hold=1
  - instruction_ready stays low until the done handshake.
- rst asserted in ACC after 2 of 8 beats:
  - next cycle IDLE, beat_cnt=0, all strobes 0
  - a new instruction is accepted normally.
- acc_len=2^ACC_W−1 with streams always valid: beat_cnt reaches 2^ACC_W−2 on the final beat and the FSM exits ACC without wrapping.
